// File: rtl/full_adder.sv
// 1-bit full adder with a registered result copy and a bit-serial mode in which
// the stored carry feeds back as carry-in, plus a saturating serial-cycle counter.
module full_adder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             serial_en,
  input  logic             clr,
  output logic             sum,
  output logic             carry,
  output logic             sum_q,
  output logic             carry_q,
  output logic [CNT_W-1:0] ops_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic cin_eff;

  // Serial mode chains the previous bit's carry straight into this bit.
  assign cin_eff = serial_en ? carry_q : c;
  assign sum     = a ^ b ^ cin_eff;
  assign carry   = (a & b) | (a & cin_eff) | (b & cin_eff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
      ops_cnt <= '0;
    end else if (clr) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
      ops_cnt <= '0;
    end else begin
      sum_q   <= sum;
      carry_q <= carry;
      // Counter sticks at all-ones rather than wrapping.
      if (serial_en && (ops_cnt != CNT_MAX))
        ops_cnt <= ops_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: directed scenarios plus randomized stimulus
// compared against an arithmetic reference model (two counter widths instantiated).
module tb_full_adder;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst, a, b, c, serial_en, clr;
  logic sum8, carry8, sum_q8, carry_q8;
  logic sum2, carry2, sum_q2, carry_q2;
  logic [7:0] ops_cnt8;
  logic [1:0] ops_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_s, m_cq, m_cnt8, m_cnt2;

  always #5 if (clk_run) clk = ~clk;

  full_adder #(.CNT_W(8)) u_fa8 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .serial_en(serial_en), .clr(clr),
    .sum(sum8), .carry(carry8), .sum_q(sum_q8), .carry_q(carry_q8), .ops_cnt(ops_cnt8)
  );

  full_adder #(.CNT_W(2)) u_fa2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .serial_en(serial_en), .clr(clr),
    .sum(sum2), .carry(carry2), .sum_q(sum_q2), .carry_q(carry_q2), .ops_cnt(ops_cnt2)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_total();
    return int'(a) + int'(b) + (serial_en ? m_cq : int'(c));
  endfunction

  task automatic check_comb(input string tag);
    int t;
    t = model_total();
    check({tag, ".sum"}, int'(sum8), t % 2);
    check({tag, ".carry"}, int'(carry8), t / 2);
    check({tag, ".sum2"}, int'(sum2), t % 2);
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".sum_q"}, int'(sum_q8), m_s);
    check({tag, ".carry_q"}, int'(carry_q8), m_cq);
    check({tag, ".ops_cnt8"}, int'(ops_cnt8), m_cnt8);
    check({tag, ".ops_cnt2"}, int'(ops_cnt2), m_cnt2);
    check({tag, ".carry_q2"}, int'(carry_q2), m_cq);
  endtask

  task automatic model_reset();
    m_s = 0; m_cq = 0; m_cnt8 = 0; m_cnt2 = 0;
  endtask

  // One rising edge; model advanced from the inputs held across the edge.
  task automatic tick(input string tag);
    int t;
    t = model_total();
    @(posedge clk);
    #1;
    if (clr) model_reset();
    else begin
      m_s  = t % 2;
      m_cq = t / 2;
      if (serial_en) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3)   m_cnt2++;
      end
    end
    check_regs(tag);
  endtask

  task automatic drive(input logic na, input logic nb, input logic nc,
                       input logic nse, input logic nclr);
    a = na; b = nb; c = nc; serial_en = nse; clr = nclr;
    #1;
  endtask

  initial begin
    logic [2:0] abc;
    logic [3:0] op_a, op_b, exp_sum_bits, exp_cq_bits;
    logic [7:0] tt_sum, tt_carry;
    logic [5:0] sat_seq;
    rst = 1'b1; a = 0; b = 0; c = 0; serial_en = 0; clr = 0;
    model_reset();
    #2;
    check_regs("reset");
    rst = 1'b0;
    #3;

    // Truth table, clock stopped
    tt_sum   = 8'b1001_0110;
    tt_carry = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      a = abc[2]; b = abc[1]; c = abc[0]; serial_en = 0;
      #10;
      check($sformatf("tt%0d.sum", i), int'(sum8), int'(tt_sum[i]));
      check($sformatf("tt%0d.carry", i), int'(carry8), int'(tt_carry[i]));
      $display("truth table abc=%03b sum=%0b carry=%0b", abc, sum8, carry8);
    end
    check_regs("tt_noclk");

    clk_run = 1'b1;
    @(posedge clk); #1;

    // Registered path
    drive(1, 1, 1, 0, 0);
    tick("reg_111");
    check("reg.sum_q_one", int'(sum_q8), 1);
    check("reg.carry_q_one", int'(carry_q8), 1);
    drive(1, 1, 1, 0, 1);
    tick("reg_clr");
    check("reg.sum_q_zero", int'(sum_q8), 0);
    $display("registered path done sum_q=%0b carry_q=%0b", sum_q8, carry_q8);

    // Serial 5 + 3
    drive(0, 0, 0, 0, 1);
    tick("ser_clr");
    op_a = 4'b0101; op_b = 4'b0011;
    exp_sum_bits = 4'b1000; exp_cq_bits = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      drive(op_a[i], op_b[i], 0, 1, 0);
      check_comb($sformatf("ser%0d", i));
      check($sformatf("ser%0d.sum_bit", i), int'(sum8), int'(exp_sum_bits[i]));
      tick($sformatf("ser%0d", i));
      check($sformatf("ser%0d.carry_q_bit", i), int'(carry_q8), int'(exp_cq_bits[i]));
      $display("serial bit %0d a=%0b b=%0b carry_q=%0b", i, op_a[i], op_b[i], carry_q8);
    end
    check("ser.ops_cnt", int'(ops_cnt8), 4);

    // Async reset mid-operation
    drive(0, 0, 0, 0, 1);
    tick("ar_clr");
    drive(1, 1, 0, 1, 0);
    tick("ar_b0");
    drive(1, 0, 0, 1, 0);
    tick("ar_b1");
    check("ar.carry_q_before", int'(carry_q8), 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_regs("ar_during");
    check("ar.carry_q_zero", int'(carry_q8), 0);
    rst = 1'b0;
    #1;
    check("ar.next_sum", int'(sum8), 1);
    check("ar.next_carry", int'(carry8), 0);
    $display("async reset mid-op sum=%0b carry=%0b", sum8, carry8);
    tick("ar_b2");

    // Saturation on the 2-bit counter
    drive(0, 0, 0, 0, 1);
    tick("sat_clr");
    sat_seq = 6'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1, 0);
      tick($sformatf("sat%0d", i));
      check($sformatf("sat%0d.cnt", i), int'(ops_cnt2), (i < 3) ? i + 1 : 3);
      $display("saturation cycle %0d ops_cnt2=%0d", i, ops_cnt2);
    end

    // Carry-in mux
    drive(0, 0, 0, 0, 1);
    tick("mux_clr");
    drive(1, 1, 0, 1, 0);
    tick("mux_set");
    check("mux.carry_q", int'(carry_q8), 1);
    drive(0, 0, 0, 1, 0);
    check("mux.serial_sum", int'(sum8), 1);
    serial_en = 0;
    #1;
    check("mux.ext_sum", int'(sum8), 0);
    check_regs("mux_hold");
    $display("carry-in mux checked");

    // Randomized
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0));
      check_comb($sformatf("rnd%0d", i));
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_regs($sformatf("rnd%0d_rst", i));
        rst = 1'b0;
        #1;
        check_comb($sformatf("rnd%0d_post", i));
      end
      tick($sformatf("rnd%0d", i));
      $display("rnd %0d a=%0b b=%0b c=%0b se=%0b clr=%0b sum_q=%0b carry_q=%0b cnt=%0d",
               i, a, b, c, serial_en, clr, sum_q8, carry_q8, ops_cnt8);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
